vector_seq_multiplier: RTL

Iterative, multi-cycle vector integer multiplier; the responder side of the execution unit's `start` / `count_0` multiply handshake. It takes two VLEN-bit operand vectors, splits them into elements by SEW, computes per-element full-width products one multiplier byte per cycle, and returns a 2×VLEN-bit product vector with a one-cycle completion pulse. It sits directly under the vector execution unit, port-compatible with its multiplier instance.

---
 rtl/vmul_pkg.sv | 28 ++
 rtl/vmul_slice.sv | 155 +++++++++++++++
 rtl/vector_seq_multiplier.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vmul_pkg.sv
// Shared types and constants for the iterative vector multiplier.
package vmul_pkg;

  localparam int unsigned VMUL_SLICE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } vmul_state_e;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_INV = 2'b11
  } vmul_sew_e;

  // Index of the most significant byte within one element (N-1).
  function automatic logic [1:0] vmul_last_byte(input vmul_sew_e s);
    case (s)
      SEW8:    return 2'd0;
      SEW16:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/vmul_slice.sv
// One 32-bit operand slice: 4/2/1 elements, 64-bit accumulator,
// byte-serial add and final sign correction.
// With VMUL_EARLY_TERM_EN defined, also reports whether every element
// has no non-zero multiplier bytes above the current byte index.
module vmul_slice
  import vmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_last,
  input  logic        i_clear,
  input  vmul_sew_e   i_sew,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  vmul_sew_e   i_sew_q,
  input  logic [1:0]  i_k,
  output logic [63:0] o_product
`ifdef VMUL_EARLY_TERM_EN
  ,
  output logic        o_rem_zero_c
`endif
);

  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [3:0]  r_sign;
  logic [63:0] r_acc;
  logic [63:0] r_product;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [3:0]  w_sign;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_res;
  logic [4:0]  w_ksh;

  assign w_ksh     = {i_k, 3'b000};
  assign o_product = r_product;

  // Per-element magnitudes and result signs from the raw operands.
  always_comb begin
    w_mag_a = '0;
    w_mag_b = '0;
    w_sign  = '0;
    case (i_sew)
      SEW8: begin
        for (int e = 0; e < 4; e++) begin
          w_mag_a[8*e +: 8] = (i_signed && i_a[8*e+7]) ? 8'(~i_a[8*e +: 8] + 8'd1) : i_a[8*e +: 8];
          w_mag_b[8*e +: 8] = (i_signed && i_b[8*e+7]) ? 8'(~i_b[8*e +: 8] + 8'd1) : i_b[8*e +: 8];
          w_sign[e]         = i_signed & (i_a[8*e+7] ^ i_b[8*e+7]);
        end
      end
      SEW16: begin
        for (int e = 0; e < 2; e++) begin
          w_mag_a[16*e +: 16] = (i_signed && i_a[16*e+15]) ? 16'(~i_a[16*e +: 16] + 16'd1) : i_a[16*e +: 16];
          w_mag_b[16*e +: 16] = (i_signed && i_b[16*e+15]) ? 16'(~i_b[16*e +: 16] + 16'd1) : i_b[16*e +: 16];
          w_sign[e]           = i_signed & (i_a[16*e+15] ^ i_b[16*e+15]);
        end
      end
      SEW32: begin
        w_mag_a   = (i_signed && i_a[31]) ? 32'(~i_a + 32'd1) : i_a;
        w_mag_b   = (i_signed && i_b[31]) ? 32'(~i_b + 32'd1) : i_b;
        w_sign[0] = i_signed & (i_a[31] ^ i_b[31]);
      end
      default: ;
    endcase
  end

  // Byte-step accumulate: |A| x byte_k(|B|) << 8k per element.
  always_comb begin
    w_acc_nxt = r_acc;
    case (i_sew_q)
      SEW8: begin
        for (int e = 0; e < 4; e++) begin
          w_acc_nxt[16*e +: 16] = r_acc[16*e +: 16]
                                + 16'(16'(r_mag_a[8*e +: 8]) * 16'(r_mag_b[8*e +: 8]));
        end
      end
      SEW16: begin
        for (int e = 0; e < 2; e++) begin
          w_acc_nxt[32*e +: 32] = r_acc[32*e +: 32]
                                + 32'((32'(r_mag_a[16*e +: 16]) * 32'(r_mag_b[16*e + int'(w_ksh) +: 8])) << w_ksh);
        end
      end
      default: begin
        w_acc_nxt = r_acc + 64'((64'(r_mag_a) * 64'(r_mag_b[int'(w_ksh) +: 8])) << w_ksh);
      end
    endcase
  end

  // Sign correction of the final accumulator, two's complement per element.
  always_comb begin
    w_res = '0;
    case (i_sew_q)
      SEW8: begin
        for (int e = 0; e < 4; e++) begin
          w_res[16*e +: 16] = r_sign[e] ? 16'(~w_acc_nxt[16*e +: 16] + 16'd1) : w_acc_nxt[16*e +: 16];
        end
      end
      SEW16: begin
        for (int e = 0; e < 2; e++) begin
          w_res[32*e +: 32] = r_sign[e] ? 32'(~w_acc_nxt[32*e +: 32] + 32'd1) : w_acc_nxt[32*e +: 32];
        end
      end
      default: begin
        w_res = r_sign[0] ? 64'(~w_acc_nxt + 64'd1) : w_acc_nxt;
      end
    endcase
  end

`ifdef VMUL_EARLY_TERM_EN
  // True when no element has a non-zero multiplier byte above index k.
  always_comb begin
    o_rem_zero_c = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (r_mag_b[8*j +: 8] != 8'd0) begin
        case (i_sew_q)
          SEW8:    ;
          SEW16:   if (2'(j % 2) > i_k) o_rem_zero_c = 1'b0;
          default: if (2'(j) > i_k)     o_rem_zero_c = 1'b0;
        endcase
      end
    end
  end
`endif

  // Operand latch, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_sign    <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      if (i_load) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_sign  <= w_sign;
        r_acc   <= '0;
      end else if (i_step) begin
        r_acc <= w_acc_nxt;
      end
      if (i_clear) begin
        r_product <= '0;
      end else if (i_step && i_last) begin
        r_product <= w_res;
      end
    end
  end

endmodule

// File: rtl/vector_seq_multiplier.sv
// Iterative vector integer multiplier, one multiplier byte per cycle.
// Optional macro VMUL_EARLY_TERM_EN: finish as soon as all remaining
// multiplier bytes of every element are zero.
module vector_seq_multiplier
  import vmul_pkg::*;
#(
  parameter int unsigned VLEN = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        sew,
  input  logic              signed_mode,
  input  logic [VLEN-1:0]   data_in_A,
  input  logic [VLEN-1:0]   data_in_B,
  output logic              count_0,
  output logic              busy,
  output logic [2*VLEN-1:0] product
);

  localparam int unsigned NSLICE = VLEN / VMUL_SLICE_W;
  localparam int unsigned PW     = 2 * VMUL_SLICE_W;

  vmul_state_e r_state;
  vmul_state_e w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  vmul_sew_e   r_sew;
  vmul_sew_e   w_sew_nxt;
  vmul_sew_e   w_sew_in;
  logic        r_count_0;
  logic        r_busy;
  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic        w_clear;
  logic        w_early;
  logic [1:0]  w_k;

  assign w_sew_in = vmul_sew_e'(sew);
  assign w_k      = 2'(vmul_last_byte(r_sew) - r_cnt);
  assign count_0  = r_count_0;
  assign busy     = r_busy;

`ifdef VMUL_EARLY_TERM_EN
  logic [NSLICE-1:0] w_rem_zero;
  assign w_early = &w_rem_zero;
`else
  assign w_early = 1'b0;
`endif

  // Next-state, counter and slice control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sew_nxt   = r_sew;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_sew_in == SEW_INV) begin
            w_clear     = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_load      = 1'b1;
            w_sew_nxt   = w_sew_in;
            w_cnt_nxt   = vmul_last_byte(w_sew_in);
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == 2'd0 || w_early) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = 2'(r_cnt - 2'd1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter, latched SEW and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_sew     <= SEW8;
      r_count_0 <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sew     <= w_sew_nxt;
      r_count_0 <= (w_state_nxt == DONE);
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  for (genvar g = 0; g < int'(NSLICE); g++) begin : g_slice
    vmul_slice u_slice (
      .clk          (clk),
      .rst_n        (reset),
      .i_load       (w_load),
      .i_step       (w_step),
      .i_last       (w_last),
      .i_clear      (w_clear),
      .i_sew        (w_sew_in),
      .i_signed     (signed_mode),
      .i_a          (data_in_A[VMUL_SLICE_W*g +: VMUL_SLICE_W]),
      .i_b          (data_in_B[VMUL_SLICE_W*g +: VMUL_SLICE_W]),
      .i_sew_q      (r_sew),
      .i_k          (w_k),
      .o_product    (product[PW*g +: PW])
`ifdef VMUL_EARLY_TERM_EN
      ,
      .o_rem_zero_c (w_rem_zero[g])
`endif
    );
  end

endmodule
